vec_mem_seq: RTL and testbench
==============================

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, which sets the memory word-address width.
REQ-002 The block SHALL have parameter LANES, default 16, which sets the number of 16-bit lanes per 256-bit vector; only 16 is supported.
REQ-003 The block SHALL have one clock, clk, an input of width 1; all state changes on its rising edge.
REQ-004 The block SHALL have rst_n, an input of width 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have start, an input of width 1, which is the request strobe.
REQ-006 The block SHALL have opcode, an input of width 4: VLD=4'b0100, VST=4'b0101.
REQ-007 The block SHALL have base_addr, an input of width ADDR_W, which is the word address of lane 0.
REQ-008 The block SHALL have wdata_vec, an input of width 256, which is the store vector; lane i is bits [16i+15:16i].
REQ-009 The block SHALL have mem_ready, an input of width 1; it indicates the memory completes the current beat this cycle.
REQ-010 The block SHALL have mem_rdata, an input of width 16, which is read data, valid when mem_ready=1 during a read.
REQ-011 The block SHALL have mem_addr, an output of width ADDR_W, which is the beat address.
REQ-012 The block SHALL have mem_wdata, an output of width 16, which is the beat write data.
REQ-013 The block SHALL have mem_re and mem_we, outputs of width 1 each, which are the read and write request levels.
REQ-014 The block SHALL have rdata_vec, an output of width 256, which is the assembled load vector.
REQ-015 The block SHALL have busy, an output of width 1, and done and err, outputs of width 1 each that are 1-cycle pulses.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, STORE and DONE; busy SHALL be 1 in every state except IDLE.
REQ-017 In IDLE, start=1 with opcode=VLD SHALL capture base_addr, clear the beat counter and enter LOAD next cycle.
REQ-018 In IDLE, start=1 with opcode=VST SHALL capture base_addr and wdata_vec into an internal register and enter STORE.
REQ-019 In IDLE, start=1 with any other opcode SHALL pulse err for 1 cycle, remain in IDLE and issue no memory request.
REQ-020 start SHALL be ignored in LOAD, STORE and DONE; the captured operands SHALL NOT change mid-operation.
REQ-021 In LOAD: mem_re=1, mem_we=0, mem_addr = captured base + cnt (modulo 2^ADDR_W, wraps silently).
REQ-022 In STORE: mem_we=1, mem_re=0, same mem_addr rule; mem_wdata = captured lane cnt.
REQ-023 The address and data outputs SHALL be held stable while mem_ready=0; any number of wait cycles is allowed.
REQ-024 On mem_ready=1 in LOAD, mem_rdata SHALL be written into rdata_vec lane cnt at that edge.
REQ-025 On mem_ready=1, cnt SHALL increment; a beat with cnt=15 SHALL transition to DONE instead.
REQ-026 In DONE: done=1, mem_re=mem_we=0; the next state SHALL be IDLE unconditionally.
REQ-027 Zero-wait latency SHALL be: start accepted at edge 0, beats at edges 1..16, done high the cycle after edge 16, IDLE after edge 17.
REQ-028 rdata_vec lanes SHALL change only on captured load beats; they SHALL hold their value through STORE, IDLE and err.
REQ-029 mem_re and mem_we SHALL never both be 1; in IDLE both SHALL be 0 and mem_addr and mem_wdata SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, cnt=0, busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata_vec=0.
REQ-031 A reset mid-operation SHALL abort the transfer with no further beats; partially written memory is not restored.
REQ-032 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 VLD at base 0x0010 with mem_ready=1 and memory[a]=a -> addresses 0x0010..0x001F in order; rdata_vec lane i=0x0010+i; done in cycle 17.
REQ-034 VST at base 0x0100 with wdata_vec lane i=0xA000+i and mem_ready toggling 1/0 -> 16 writes, each beat held stable across wait cycles, memory[0x100+i]=0xA000+i, single done pulse.
REQ-035 VLD at base 0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007; no err.
REQ-036 start with opcode=4'b0000 (VADD) -> err pulse of 1 cycle, busy stays 0, no mem_re or mem_we; a following VLD works normally.
REQ-037 A second start during LOAD with a different base -> ignored; the address sequence is unchanged.
REQ-038 rst_n low after beat 5 of a VST -> all outputs 0 asynchronously (before the next edge), IDLE; a new VLD then completes correctly.

Source files
------------

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - 16-lane vector load/store sequencer over a 16-bit word memory port
module vec_mem_seq #(
    parameter int ADDR_W = 16,
    parameter int LANES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [16*LANES-1:0]   wdata_vec,
    input  logic                  mem_ready,
    input  logic [15:0]           mem_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [16*LANES-1:0]   rdata_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;
    localparam int         CNT_W  = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [16*LANES-1:0]   wvec_q, wvec_d;
    logic [16*LANES-1:0]   rvec_q, rvec_d;
    logic                  err_q, err_d;
    logic [15:0]           lane_wdata;

    // Select the captured store lane addressed by the beat counter
    always_comb begin
        lane_wdata = 16'h0000;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                lane_wdata = wvec_q[16*i +: 16];
            end
        end
    end

    // Next-state, beat sequencing and memory-port outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wvec_d    = wvec_q;
        rvec_d    = rvec_q;
        err_d     = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'h0000;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_VLD: begin
                            base_d  = base_addr;
                            cnt_d   = '0;
                            state_d = S_LOAD;
                        end
                        OP_VST: begin
                            base_d  = base_addr;
                            wvec_d  = wdata_vec;
                            cnt_d   = '0;
                            state_d = S_STORE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                mem_re   = 1'b1;
                mem_addr = base_q + ADDR_W'(cnt_q);
                if (mem_ready) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            rvec_d[16*i +: 16] = mem_rdata;
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STORE: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(cnt_q);
                mem_wdata = lane_wdata;
                if (mem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and operand registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            wvec_q  <= '0;
            rvec_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            wvec_q  <= wvec_d;
            rvec_q  <= rvec_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign rdata_vec = rvec_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - randomized directed bench for vec_mem_seq against a memory/vector model
module tb_vec_mem_seq;

    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   opcode;
    logic [15:0]  base_addr;
    logic [255:0] wdata_vec;
    logic         mem_ready;
    logic [15:0]  mem_rdata;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_re;
    logic         mem_we;
    logic [255:0] rdata_vec;
    logic         busy;
    logic         done;
    logic         err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0]  mem [0:65535];
    logic [255:0] rvec_m;

    vec_mem_seq #(.ADDR_W(16), .LANES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .base_addr (base_addr),
        .wdata_vec (wdata_vec),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .rdata_vec (rdata_vec),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_re"}, mem_re, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, 16'h0);
        check({tag, "_wdata"}, mem_wdata, 16'h0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_rvec"}, rdata_vec, rvec_m);
    endtask

    // One vector operation; mode 0 = always ready, 1 = ready toggling 1/0, 2 = random ready
    task automatic run_op(input logic [3:0] op, input logic [15:0] base, input logic [255:0] wv,
                          input int mode, input int intrude_cyc, input int abort_beat, output int cycles);
        logic        is_ld;
        logic        rdy;
        logic [15:0] a;
        int          k;
        int          c;
        is_ld = (op == VLD);
        k = 0;
        c = 0;
        @(negedge clk);
        start = 1'b1; opcode = op; base_addr = base; wdata_vec = wv; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; opcode = 4'($urandom); base_addr = 16'($urandom); wdata_vec = {8{$urandom}};
        while (k < 16 && c < 400) begin
            if (k == abort_beat) begin
                mem_ready = 1'b0;
                rst_n = 1'b0;
                #1;
                rvec_m = '0;
                check_quiet("abort");
                @(negedge clk);
                rst_n = 1'b1;
                cycles = c;
                return;
            end
            a = base + 16'(k);
            check("beat_busy", busy, 1'b1);
            check("beat_re", mem_re, is_ld);
            check("beat_we", mem_we, !is_ld);
            check("beat_addr", mem_addr, a);
            if (!is_ld) check("beat_wdata", mem_wdata, wv[16*k +: 16]);
            check("beat_done", done, 1'b0);
            check("beat_err", err, 1'b0);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (c[0] == 1'b0);
            else                rdy = 1'($urandom_range(0, 1));
            mem_ready = rdy;
            mem_rdata = rdy ? mem[a] : 16'($urandom);
            if (c == intrude_cyc) begin
                start = 1'b1; opcode = VLD; base_addr = base ^ 16'h5555;
            end else begin
                start = 1'b0;
            end
            if (rdy) begin
                if (is_ld) rvec_m[16*k +: 16] = mem[a];
                else       mem[a] = wv[16*k +: 16];
                k++;
            end
            c++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        start = 1'b0;
        check("beat_count", 256'(k), 256'(16));
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b1);
        check("done_re", mem_re, 1'b0);
        check("done_we", mem_we, 1'b0);
        @(negedge clk);
        check_quiet("post");
        cycles = c;
    endtask

    task automatic bad_op(input logic [3:0] op);
        @(negedge clk);
        start = 1'b1; opcode = op; base_addr = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_re", mem_re, 1'b0);
        check("err_we", mem_we, 1'b0);
        check("err_rvec", rdata_vec, rvec_m);
        @(negedge clk);
        check("err_clear", err, 1'b0);
        check("err_idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [255:0] wv;
        logic [255:0] lane_exp;
        logic [3:0]   rop;
        int           cyc;

        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; base_addr = 16'h0;
        wdata_vec = '0; mem_ready = 1'b0; mem_rdata = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
        rvec_m = '0;

        @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // Zero-wait load at 0x0010 over memory[a]=a
        run_op(VLD, 16'h0010, '0, 0, -1, -1, cyc);
        check("vld_latency", 256'(cyc), 256'(16));
        for (int i = 0; i < 16; i++) lane_exp[16*i +: 16] = 16'h0010 + 16'(i);
        check("vld_lanes", rdata_vec, lane_exp);

        // Store at 0x0100 with ready toggling, then read it back
        for (int i = 0; i < 16; i++) wv[16*i +: 16] = 16'hA000 + 16'(i);
        run_op(VST, 16'h0100, wv, 1, -1, -1, cyc);
        run_op(VLD, 16'h0100, '0, 0, -1, -1, cyc);
        check("vst_readback", rdata_vec, wv);

        // Wrapping load at 0xFFF8 with random waits
        run_op(VLD, 16'hFFF8, '0, 2, -1, -1, cyc);

        // Every unsupported opcode pulses err and leaves memory untouched
        for (int op = 0; op < 16; op++) begin
            if (op != 4 && op != 5) bad_op(4'(op));
        end
        run_op(VLD, 16'h0200, '0, 0, -1, -1, cyc);

        // Second start mid-load with a different base is ignored
        run_op(VLD, 16'h0300, '0, 0, 3, -1, cyc);

        // Reset after five store beats, then a fresh load over the partly written region
        for (int i = 0; i < 16; i++) wv[16*i +: 16] = 16'($urandom);
        run_op(VST, 16'h0400, wv, 0, -1, 5, cyc);
        check_quiet("post_reset");
        run_op(VLD, 16'h0400, '0, 2, -1, -1, cyc);

        // Random mix of loads and stores
        for (int t = 0; t < 8; t++) begin
            rop = ($urandom_range(0, 1) == 0) ? VLD : VST;
            wv  = {8{$urandom}};
            run_op(rop, 16'($urandom), wv, int'($urandom_range(0, 2)), -1, -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
